// File: rtl/mem_stage.sv
// mem_stage: memory-access stage that sits after the execute-stage ALU.
//   ADD/SUB results go straight to writeback. LOAD/STR use the ALU result as
//   the address and run a req/ack transaction with a variable-latency memory.
//   The stage holds one operation at a time, and every output except
//   in_ready is registered.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_valid/ready  upstream handshake (in_ready is combinational)
//   in_opcode       000 ADD, 001 SUB, 100 LOAD, 101 STR, anything else illegal
//   in_result       ALU result, or the memory address for LOAD/STR
//   in_store_data   write data for STR
//   in_rd           destination register
//   mem_*           memory request/acknowledge interface
//   wb_valid/rd/data  single-cycle writeback pulse
//   illegal_op      pulse: an illegal opcode was dropped
//   mem_timeout     pulse: memory operation abandoned without an ack
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | ready to accept an operation
// S_MEM_WAIT | mem_req held high, waiting for mem_ack or the timeout
// S_WB       | wb_valid high for this one cycle
module mem_stage #(
   parameter int WIDTH   = 16,
   parameter int RD_W    = 3,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_opcode,
   input  logic [WIDTH-1:0] in_result,
   input  logic [WIDTH-1:0] in_store_data,
   input  logic [RD_W-1:0]  in_rd,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic             wb_valid,
   output logic [RD_W-1:0]  wb_rd,
   output logic [WIDTH-1:0] wb_data,
   output logic             illegal_op,
   output logic             mem_timeout
);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_LOAD = 3'b100;
   localparam logic [2:0] OP_STR  = 3'b101;

   // The counter only has to reach TIMEOUT-1, which is the last cycle
   // counted in MEM_WAIT.
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_WB} state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RD_W-1:0]  rd_q, rd_d;
   logic             mem_req_d, mem_we_d, wb_valid_d, illegal_d, timeout_d;
   logic [WIDTH-1:0] mem_addr_d, mem_wdata_d, wb_data_d;
   logic [RD_W-1:0]  wb_rd_d;
   logic             xfer;

   assign in_ready = (state == S_IDLE) && !rst;
   assign xfer     = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt_q       <= '0;
         rd_q        <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         wb_valid    <= 1'b0;
         wb_rd       <= '0;
         wb_data     <= '0;
         illegal_op  <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         state       <= state_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         mem_req     <= mem_req_d;
         mem_we      <= mem_we_d;
         mem_addr    <= mem_addr_d;
         mem_wdata   <= mem_wdata_d;
         wb_valid    <= wb_valid_d;
         wb_rd       <= wb_rd_d;
         wb_data     <= wb_data_d;
         illegal_op  <= illegal_d;
         mem_timeout <= timeout_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE: begin
            if (xfer) begin
               case (in_opcode)
                  OP_ADD, OP_SUB:  state_d = S_WB;
                  OP_LOAD, OP_STR: state_d = S_MEM_WAIT;
                  default:         state_d = S_IDLE;
               endcase
            end
         end
         S_MEM_WAIT: begin
            // An ack in the last counted cycle takes priority over the timeout.
            if (mem_ack)               state_d = mem_we ? S_IDLE : S_WB;
            else if (cnt_q == CNT_LAST) state_d = S_IDLE;
         end
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // These are the values the output registers load at the next edge.
   // Data outputs keep their contents unless an operation writes them.
   always_comb begin
      mem_req_d   = 1'b0;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      wb_valid_d  = 1'b0;
      wb_rd_d     = wb_rd;
      wb_data_d   = wb_data;
      illegal_d   = 1'b0;
      timeout_d   = 1'b0;
      rd_d        = rd_q;
      cnt_d       = '0;
      case (state)
         S_IDLE: begin
            if (xfer) begin
               case (in_opcode)
                  OP_ADD, OP_SUB: begin
                     wb_valid_d = 1'b1;
                     wb_rd_d    = in_rd;
                     wb_data_d  = in_result;
                  end
                  OP_LOAD: begin
                     mem_req_d  = 1'b1;
                     mem_we_d   = 1'b0;
                     mem_addr_d = in_result;
                     rd_d       = in_rd;
                  end
                  OP_STR: begin
                     mem_req_d   = 1'b1;
                     mem_we_d    = 1'b1;
                     mem_addr_d  = in_result;
                     mem_wdata_d = in_store_data;
                  end
                  default: illegal_d = 1'b1;
               endcase
            end
         end
         S_MEM_WAIT: begin
            if (mem_ack) begin
               if (!mem_we) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = rd_q;
                  wb_data_d  = mem_rdata;
               end
            end else if (cnt_q == CNT_LAST) begin
               timeout_d = 1'b1;
            end else begin
               mem_req_d = 1'b1;
               cnt_d     = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   localparam int WIDTH   = 16;
   localparam int RD_W    = 3;
   localparam int TIMEOUT = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_opcode;
   logic [WIDTH-1:0] in_result;
   logic [WIDTH-1:0] in_store_data;
   logic [RD_W-1:0]  in_rd;
   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ack;
   logic             wb_valid;
   logic [RD_W-1:0]  wb_rd;
   logic [WIDTH-1:0] wb_data;
   logic             illegal_op;
   logic             mem_timeout;

   int n_tests = 0;
   int n_fail  = 0;

   mem_stage #(.WIDTH(WIDTH), .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_opcode     (in_opcode),
      .in_result     (in_result),
      .in_store_data (in_store_data),
      .in_rd         (in_rd),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_ack       (mem_ack),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .illegal_op    (illegal_op),
      .mem_timeout   (mem_timeout)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_opcode = 3'b000; in_result = '0; in_store_data = '0;
      in_rd = '0; mem_rdata = '0; mem_ack = 1'b0;
      step(); step();
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
      rst = 1'b0;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready); end
      n_tests++; if ({mem_req, mem_we, wb_valid, illegal_op, mem_timeout} !== 5'b0) begin
         n_fail++; $display("FAIL reset_strobes: got %b want 00000", {mem_req, mem_we, wb_valid, illegal_op, mem_timeout}); end
      n_tests++; if ({mem_addr, mem_wdata, wb_data, wb_rd} !== '0) begin
         n_fail++; $display("FAIL reset_data: addr %h wdata %h wb_data %h wb_rd %0d want 0", mem_addr, mem_wdata, wb_data, wb_rd); end
      step();
   endtask

   task automatic test_add();
      in_valid = 1'b1; in_opcode = 3'b000; in_result = 16'h1234; in_rd = 3'd5;
      step();
      in_valid = 1'b0;
      n_tests++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL add_wb_valid: got %b want 1", wb_valid); end
      n_tests++; if (wb_rd !== 3'd5) begin n_fail++; $display("FAIL add_wb_rd: got %0d want 5", wb_rd); end
      n_tests++; if (wb_data !== 16'h1234) begin n_fail++; $display("FAIL add_wb_data: got %h want 1234", wb_data); end
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL add_no_mem_req: got %b want 0", mem_req); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add_busy: in_ready got %b want 0", in_ready); end
      step();
      n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL add_wb_single: got %b want 0", wb_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready_again: got %b want 1", in_ready); end
   endtask

   task automatic test_load();
      in_valid = 1'b1; in_opcode = 3'b100; in_result = 16'h00A0; in_rd = 3'd2;
      step();
      in_valid = 1'b0; in_result = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         n_tests++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h00A0}) begin
            n_fail++; $display("FAIL load_req_cycle%0d: req %b we %b addr %h want 1 0 00a0", i, mem_req, mem_we, mem_addr); end
         n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL load_early_wb%0d: got %b want 0", i, wb_valid); end
         if (i == 2) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
         step();
      end
      mem_ack = 1'b0; mem_rdata = 16'h0000;
      n_tests++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL load_wb_valid: got %b want 1", wb_valid); end
      n_tests++; if (wb_data !== 16'hBEEF) begin n_fail++; $display("FAIL load_wb_data: got %h want beef", wb_data); end
      n_tests++; if (wb_rd !== 3'd2) begin n_fail++; $display("FAIL load_wb_rd: got %0d want 2", wb_rd); end
      n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL load_req_drop: got %b want 0", mem_req); end
      step();
      n_tests++; if ({wb_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL load_done: wb_valid,in_ready got %b want 01", {wb_valid, in_ready}); end
   endtask

   task automatic test_store();
      in_valid = 1'b1; in_opcode = 3'b101; in_result = 16'h0010; in_store_data = 16'h5A5A; in_rd = 3'd6;
      step();
      in_valid = 1'b0; in_store_data = 16'h0000;
      n_tests++; if ({mem_req, mem_we} !== 2'b11) begin n_fail++; $display("FAIL store_req_we: got %b want 11", {mem_req, mem_we}); end
      n_tests++; if (mem_wdata !== 16'h5A5A) begin n_fail++; $display("FAIL store_wdata: got %h want 5a5a", mem_wdata); end
      n_tests++; if (mem_addr !== 16'h0010) begin n_fail++; $display("FAIL store_addr: got %h want 0010", mem_addr); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL store_busy: got %b want 0", in_ready); end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      n_tests++; if ({in_ready, mem_req, wb_valid} !== 3'b100) begin
         n_fail++; $display("FAIL store_done: ready,req,wb got %b want 100", {in_ready, mem_req, wb_valid}); end
      step();
      n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL store_no_wb: got %b want 0", wb_valid); end
   endtask

   task automatic test_timeout();
      int cnt;
      bit wb_seen;
      cnt = 0; wb_seen = 1'b0;
      in_valid = 1'b1; in_opcode = 3'b100; in_result = 16'h0300; in_rd = 3'd7;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 40 && mem_req; i++) begin
         cnt++;
         if (wb_valid || mem_timeout) wb_seen = 1'b1;
         step();
      end
      n_tests++; if (cnt !== TIMEOUT) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want %0d", cnt, TIMEOUT); end
      n_tests++; if (wb_seen !== 1'b0) begin n_fail++; $display("FAIL timeout_early_pulse: got %b want 0", wb_seen); end
      n_tests++; if ({mem_timeout, in_ready, wb_valid} !== 3'b110) begin
         n_fail++; $display("FAIL timeout_pulse: timeout,ready,wb got %b want 110", {mem_timeout, in_ready, wb_valid}); end
      step();
      n_tests++; if ({mem_timeout, wb_valid} !== 2'b00) begin n_fail++; $display("FAIL timeout_single: got %b want 00", {mem_timeout, wb_valid}); end
   endtask

   task automatic test_ack_last_cycle();
      bit to_seen;
      to_seen = 1'b0;
      in_valid = 1'b1; in_opcode = 3'b100; in_result = 16'h0400; in_rd = 3'd1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         if (mem_timeout) to_seen = 1'b1;
         if (i == TIMEOUT - 1) begin
            n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL acklast_req16: got %b want 1", mem_req); end
            mem_ack = 1'b1; mem_rdata = 16'hCAFE;
         end
         step();
      end
      mem_ack = 1'b0;
      n_tests++; if ({wb_valid, mem_timeout, to_seen} !== 3'b100) begin
         n_fail++; $display("FAIL acklast_wins: wb,timeout,early got %b want 100", {wb_valid, mem_timeout, to_seen}); end
      n_tests++; if ({wb_data, wb_rd} !== {16'hCAFE, 3'd1}) begin
         n_fail++; $display("FAIL acklast_data: got %h/%0d want cafe/1", wb_data, wb_rd); end
      step();
      n_tests++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL acklast_no_timeout: got %b want 0", mem_timeout); end
   endtask

   task automatic test_illegal();
      in_valid = 1'b1; in_opcode = 3'b011; in_result = 16'h9999; in_rd = 3'd4;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready_pre: got %b want 1", in_ready); end
      step();
      in_opcode = 3'b000; in_result = 16'h4321; in_rd = 3'd3;
      n_tests++; if ({illegal_op, in_ready, mem_req, wb_valid} !== 4'b1100) begin
         n_fail++; $display("FAIL illegal_pulse: illegal,ready,req,wb got %b want 1100", {illegal_op, in_ready, mem_req, wb_valid}); end
      step();
      in_valid = 1'b0;
      n_tests++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL illegal_single: got %b want 0", illegal_op); end
      n_tests++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 16'h4321, 3'd3}) begin
         n_fail++; $display("FAIL illegal_then_add: got %b %h %0d want 1 4321 3", wb_valid, wb_data, wb_rd); end
      step();
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; in_opcode = 3'b001; in_result = 16'h0F0F; in_rd = 3'd6;
      step();
      in_opcode = 3'b000; in_result = 16'hA5A5; in_rd = 3'd0;
      n_tests++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 16'h0F0F, 3'd6}) begin
         n_fail++; $display("FAIL b2b_sub: got %b %h %0d want 1 0f0f 6", wb_valid, wb_data, wb_rd); end
      step();
      n_tests++; if ({wb_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_gap: wb,ready got %b want 01", {wb_valid, in_ready}); end
      step();
      in_valid = 1'b0;
      n_tests++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 16'hA5A5, 3'd0}) begin
         n_fail++; $display("FAIL b2b_add: got %b %h %0d want 1 a5a5 0", wb_valid, wb_data, wb_rd); end
      step();
   endtask

   task automatic test_reset_mid();
      bit stray;
      stray = 1'b0;
      in_valid = 1'b1; in_opcode = 3'b100; in_result = 16'h0777; in_rd = 3'd4;
      step();
      in_valid = 1'b0;
      step();
      n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_pre: got %b want 1", mem_req); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++; if ({mem_req, mem_we, wb_valid, illegal_op, mem_timeout} !== 5'b0) begin
         n_fail++; $display("FAIL rstmid_strobes: got %b want 00000", {mem_req, mem_we, wb_valid, illegal_op, mem_timeout}); end
      n_tests++; if ({mem_addr, mem_wdata, wb_data, wb_rd} !== '0) begin
         n_fail++; $display("FAIL rstmid_data: addr %h wdata %h wb_data %h wb_rd %0d want 0", mem_addr, mem_wdata, wb_data, wb_rd); end
      mem_ack = 1'b1; mem_rdata = 16'hFFFF;
      step();
      mem_ack = 1'b0;
      for (int i = 0; i < TIMEOUT + 4; i++) begin
         if (wb_valid || mem_timeout || mem_req) stray = 1'b1;
         step();
      end
      n_tests++; if ({stray, in_ready} !== 2'b01) begin n_fail++; $display("FAIL rstmid_stray_ack: stray,ready got %b want 01", {stray, in_ready}); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_load();
      test_store();
      test_timeout();
      test_ack_last_cycle();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
